valid_ready_skid_buffer: RTL

- Two-entry valid/ready buffer that registers both the forward path (read_valid, read_data) and the backward path (write_ready).
- It is the counterpart of valid_ready_bypass_buffer, which is combinational write-to-read when empty. This block has no combinational path between its write and read interfaces.
- Used to cut timing on long valid/ready links at full throughput, one transfer per cycle.
- Sits between any valid/ready producer and consumer in the data building blocks.

---
 rtl/valid_ready_skid_buffer.sv | 100 ++++++++++
 1 files changed

// File: rtl/valid_ready_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : valid_ready_skid_buffer
//  Description : Two-entry valid/ready buffer. read_valid, read_data and
//                write_ready are all register outputs or decodes of state, so
//                no combinational path runs from the write side to the read
//                side. It sustains one transfer per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module valid_ready_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_valid,
  output logic             write_ready,
  output logic             full,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid,
  input  logic             read_ready,
  output logic             empty
);

  // EMPTY: nothing held. BUSY: main holds the oldest word.
  // FULL: main holds the oldest word and skid holds the next one.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_next;
  logic [WIDTH-1:0] w_skid_next;
  logic             w_write;
  logic             w_read;

  // Handshakes qualified by the registered flags only
  assign w_write = write_valid & write_ready;
  assign w_read  = read_valid & read_ready;

  // Next state and storage updates; main always holds the oldest entry
  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    case (r_state)
      S_EMPTY: begin
        if (w_write) begin
          w_state_next = S_BUSY;
          w_main_next  = write_data;
        end
      end
      S_BUSY: begin
        if (w_write && !w_read) begin
          w_state_next = S_FULL;
          w_skid_next  = write_data;
        end else if (w_read && !w_write) begin
          w_state_next = S_EMPTY;
        end else if (w_write && w_read) begin
          w_main_next  = write_data;
        end
      end
      S_FULL: begin
        if (w_read) begin
          w_state_next = S_BUSY;
          w_main_next  = r_skid;
        end
      end
      default: begin
        w_state_next = S_EMPTY;
      end
    endcase
  end

  // State and storage registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_next;
      r_main  <= w_main_next;
      r_skid  <= w_skid_next;
    end
  end

  assign read_valid  = (r_state != S_EMPTY);
  assign write_ready = (r_state != S_FULL);
  assign empty       = (r_state == S_EMPTY);
  assign full        = (r_state == S_FULL);
  assign read_data   = r_main;

endmodule
`default_nettype wire
